microcode_sequencer: RTL and testbench

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

---
 rtl/microcode_sequencer.sv | 141 ++++++++++++++
 tb/tb_microcode_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microprogram sequencer: pc, branch decode, optional return stack.
// Optional call/return stack enabled by macro MSEQ_CALL_STACK_EN.
module microcode_sequencer #(
  parameter int CW_W        = 16,
  parameter int AW          = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 zero_flag,
  input  logic                 neg_flag,
  output logic [AW-1:0]        rom_addr,
  input  logic [4+AW+CW_W:0]   rom_word,
  output logic [CW_W-1:0]      cw,
  output logic                 done,
  output logic                 err,
  output logic [4:0]           sp
);

  localparam int RW = 4 + AW + CW_W + 1;

  localparam logic [3:0] OP_NEXT  = 4'd0;
  localparam logic [3:0] OP_JMP   = 4'd1;
  localparam logic [3:0] OP_JZ    = 4'd2;
  localparam logic [3:0] OP_JNZ   = 4'd3;
  localparam logic [3:0] OP_JNEG  = 4'd4;
  localparam logic [3:0] OP_JNNEG = 4'd5;
  localparam logic [3:0] OP_WAIT  = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd7;
  localparam logic [3:0] OP_CALL  = 4'd8;
  localparam logic [3:0] OP_RET   = 4'd9;

  logic [AW-1:0] r_pc;
  logic [3:0]    w_op;
  logic [AW-1:0] w_tgt;
  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_next;

  assign w_op     = rom_word[RW-1 -: 4];
  assign w_tgt    = rom_word[RW-5 -: AW];
  assign w_inc    = r_pc + 1'b1;
  assign cw       = rom_word[CW_W:1];
  assign done     = rom_word[0];
  assign rom_addr = r_pc;

`ifdef MSEQ_CALL_STACK_EN
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [4:0] SP_MAX = 5'(STACK_DEPTH);

  logic [AW-1:0] r_stack [STACK_DEPTH];
  logic [4:0]    r_sp;
  logic          r_err;
  logic [4:0]    w_sp_m1;
  logic          w_push;
  logic          w_pop;
  logic          w_fault;

  assign w_sp_m1 = r_sp - 5'd1;
  assign sp      = r_sp;
  assign err     = r_err;

  // Next-pc decode including stack push/pop requests
  always_comb begin
    w_next  = w_inc;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_fault = 1'b0;
    case (w_op)
      OP_JMP:   w_next = w_tgt;
      OP_JZ:    w_next = zero_flag ? w_tgt : w_inc;
      OP_JNZ:   w_next = zero_flag ? w_inc : w_tgt;
      OP_JNEG:  w_next = neg_flag ? w_tgt : w_inc;
      OP_JNNEG: w_next = neg_flag ? w_inc : w_tgt;
      OP_WAIT:  w_next = start ? w_inc : r_pc;
      OP_HALT:  w_next = r_pc;
      OP_CALL: begin
        if (r_sp < SP_MAX) begin
          w_push = 1'b1;
          w_next = w_tgt;
        end else begin
          w_fault = 1'b1;
        end
      end
      OP_RET: begin
        if (r_sp != 5'd0) begin
          w_pop  = 1'b1;
          w_next = r_stack[w_sp_m1[IW-1:0]];
        end else begin
          w_fault = 1'b1;
        end
      end
      default:  w_next = w_inc;
    endcase
  end

  // pc, occupancy and sticky error update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= '0;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc <= w_next;
      if (w_push) r_sp <= r_sp + 5'd1;
      if (w_pop)  r_sp <= w_sp_m1;
      if (w_fault) r_err <= 1'b1;
    end
  end

  // Return-address storage; contents need no reset
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_stack[r_sp[IW-1:0]] <= w_inc;
  end
`else
  assign sp  = 5'd0;
  assign err = 1'b0;

  // Next-pc decode; call/return codes behave as NEXT
  always_comb begin
    w_next = w_inc;
    case (w_op)
      OP_JMP:   w_next = w_tgt;
      OP_JZ:    w_next = zero_flag ? w_tgt : w_inc;
      OP_JNZ:   w_next = zero_flag ? w_inc : w_tgt;
      OP_JNEG:  w_next = neg_flag ? w_tgt : w_inc;
      OP_JNNEG: w_next = neg_flag ? w_inc : w_tgt;
      OP_WAIT:  w_next = start ? w_inc : r_pc;
      OP_HALT:  w_next = r_pc;
      default:  w_next = w_inc;
    endcase
  end

  // pc update
  always_ff @(posedge clk) begin
    if (reset) r_pc <= '0;
    else       r_pc <= w_next;
  end
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed programs plus random
// programs checked against a queue-based reference model.
module tb_microcode_sequencer;

  localparam int CW_W  = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int RW    = 4 + AW + CW_W + 1;

`ifdef MSEQ_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            zero_flag;
  logic            neg_flag;
  logic [AW-1:0]   rom_addr;
  logic [RW-1:0]   rom_word;
  logic [CW_W-1:0] cw;
  logic            done;
  logic            err;
  logic [4:0]      sp;

  logic [RW-1:0] rom [16];

  int checks = 0;
  int errors = 0;

  int m_pc;
  int m_q[$];
  bit m_err;

  always #5 clk = ~clk;

  assign rom_word = rom[rom_addr];

  microcode_sequencer #(
    .CW_W(CW_W), .AW(AW), .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .zero_flag(zero_flag), .neg_flag(neg_flag),
    .rom_addr(rom_addr), .rom_word(rom_word),
    .cw(cw), .done(done), .err(err), .sp(sp)
  );

  function automatic logic [RW-1:0] mk(input int op, input int t,
                                       input bit d);
    logic [3:0]    o;
    logic [AW-1:0] ta;
    logic [15:0]   c;
    o  = 4'(op);
    ta = AW'(t);
    c  = 16'($urandom);
    return {o, ta, c, d};
  endfunction

  task automatic m_reset();
    m_pc = 0;
    m_q.delete();
    m_err = 1'b0;
  endtask

  task automatic m_advance();
    logic [RW-1:0] w;
    int op, t, inc, np;
    w   = rom[m_pc];
    op  = int'(w[RW-1 -: 4]);
    t   = int'(w[RW-5 -: AW]);
    inc = (m_pc + 1) % 16;
    np  = inc;
    case (op)
      1: np = t;
      2: np = zero_flag ? t : inc;
      3: np = !zero_flag ? t : inc;
      4: np = neg_flag ? t : inc;
      5: np = !neg_flag ? t : inc;
      6: np = start ? inc : m_pc;
      7: np = m_pc;
      8: if (STK) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(inc);
          np = t;
        end else m_err = 1'b1;
      end
      9: if (STK) begin
        if (m_q.size() > 0) np = m_q.pop_back();
        else m_err = 1'b1;
      end
      default: np = inc;
    endcase
    m_pc = np;
  endtask

  task automatic check(input string tag);
    logic [RW-1:0] w;
    w = rom[m_pc];
    checks++;
    assert (rom_addr === AW'(m_pc)) else begin
      errors++;
      $error("FAIL %s addr: got %0d want %0d", tag, rom_addr, m_pc);
    end
    checks++;
    assert (cw === w[CW_W:1]) else begin
      errors++;
      $error("FAIL %s cw: got %h want %h", tag, cw, w[CW_W:1]);
    end
    checks++;
    assert (done === w[0]) else begin
      errors++;
      $error("FAIL %s done: got %b want %b", tag, done, w[0]);
    end
    checks++;
    assert (sp === 5'(m_q.size())) else begin
      errors++;
      $error("FAIL %s sp: got %0d want %0d", tag, sp, m_q.size());
    end
    checks++;
    assert (err === m_err) else begin
      errors++;
      $error("FAIL %s err: got %b want %b", tag, err, m_err);
    end
  endtask

  task automatic step(input string tag, input bit r);
    reset = r;
    #1;
    check(tag);
    if (r) m_reset();
    else m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_next();
    for (int i = 0; i < 16; i++) rom[i] = mk(0, 0, 1'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    zero_flag = 1'b0;
    neg_flag = 1'b0;
    fill_next();
    rom[0]  = mk(6, 0, 0);
    rom[1]  = mk(1, 2, 0);
    rom[2]  = mk(2, 7, 0);
    rom[3]  = mk(4, 8, 1);
    rom[4]  = mk(8, 12, 0);
    rom[5]  = mk(9, 0, 0);
    rom[6]  = mk(1, 15, 1);
    rom[7]  = mk(1, 2, 0);
    rom[8]  = mk(5, 3, 0);
    rom[12] = mk(9, 0, 1);
    rom[15] = mk(0, 0, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    step("reset", 0);
    step("wait0", 0);
    step("wait1", 0);
    start = 1'b1;
    step("go", 0);
    start = 1'b0;
    step("jmp", 0);
    zero_flag = 1'b1;
    step("jz_t", 0);
    zero_flag = 1'b0;
    step("jmp7", 0);
    step("jz_nt", 0);
    neg_flag = 1'b1;
    step("jneg_t", 0);
    neg_flag = 1'b0;
    step("jnneg_t", 0);
    step("jneg_nt", 0);
    step("call", 0);
    step("ret", 0);
    step("ret_unf", 0);
    step("jmp15", 0);
    step("wrap", 0);
    step("at0", 0);

    fill_next();
    rom[0] = mk(8, 1, 0);
    rom[1] = mk(8, 2, 0);
    rom[2] = mk(8, 5, 0);
    rom[3] = mk(7, 0, 1);
    step("rst2", 1);
    step("call1", 0);
    step("call2", 0);
    step("call_ovf", 0);
    for (int i = 0; i < 4; i++) begin
      rom[3] = mk(7, 0, 1'($urandom));
      step("halt", 0);
    end
    rom[3] = mk(1, 1, 0);
    step("jmp1", 0);
    step("rst_call", 1);
    step("post_rst", 0);

    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        for (int j = 0; j < 16; j++)
          rom[j] = mk($urandom_range(0, 15), $urandom_range(0, 15),
                      1'($urandom));
      end
      zero_flag = 1'($urandom);
      neg_flag  = 1'($urandom);
      start     = 1'($urandom);
      step("rand", (i % 50 == 0) || ($urandom_range(0, 99) < 3));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
